// File: rtl/dram_sp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dram_sp_pkg
//  Description : Shared definitions for the single-port distributed RAM
//                generator. Holds the clear-sequencer state encoding and the
//                write-mode selector constants.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package dram_sp_pkg;

  // Clear sequencer state encoding.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Write-mode selectors for the registered read port.
  localparam int WMODE_RF = 0;  // read-first: dout shows the old word
  localparam int WMODE_WF = 1;  // write-first: dout shows the new word

endpackage : dram_sp_pkg
`default_nettype wire

// File: rtl/dram_sp_clr.sv
`default_nettype none
// ============================================================================
//  Module      : dram_sp_clr
//  Description : Clear sequencer. Walks every word address once, asserting a
//                write enable so the top level can zero the array. Entered on
//                reset or on a clear request while idle.
//  Ports       : clk      - clock
//                rst      - synchronous active-high reset (starts a clear)
//                clr      - clear request (ignored while a clear is running)
//                busy     - high for exactly DEPTH cycles per clear
//                clr_addr - address being zeroed this cycle
//                clr_we   - write enable for the zeroing write
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_sp_clr
  import dram_sp_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic [AW-1:0] clr_addr,
  output logic          clr_we
);

  // Last address of the array (DEPTH-1) is the all-ones AW-bit value.
  localparam logic [AW-1:0] CNT_LAST = '1;

  clr_state_e    state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          // clr is deliberately not looked at here: a running clear is
          // neither restarted nor extended by another request.
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // All outputs are straight decodes of flop outputs.
  assign busy     = (state == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule : dram_sp_clr
`default_nettype wire

// File: rtl/dram_sp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : dram_sp_gen
//  Description : Parameterised single-port distributed RAM with asynchronous
//                array read, synchronous write, optional output register with
//                read-first / write-first behaviour, and a self-timed
//                whole-array clear sequence.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset (launches a clear)
//                clr  - request to zero the whole array
//                wre  - write enable (ignored while busy or with clr)
//                ad   - word address shared by read and write
//                di   - write data
//                dout - read data
//                busy - clear sequence in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_sp_gen
  import dram_sp_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int OREG  = 1,
  parameter int WMODE = WMODE_RF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wre,
  input  logic [AW-1:0] ad,
  input  logic [DW-1:0] di,
  output logic [DW-1:0] dout,
  output logic          busy
);

  localparam int DEPTH = 1 << AW;

  // Storage has no reset; its contents come only from the clear sequence
  // and user writes.
  logic [DW-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          user_we;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;

  dram_sp_clr #(
    .AW (AW)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  // A user write is dropped while clearing, and also when it coincides with
  // a clear request (the clear takes priority).
  assign user_we = wre & ~busy & ~clr;

  // Write-port mux: the clear sequencer owns the port whenever it is active.
  assign wr_en   = clr_we | user_we;
  assign wr_addr = clr_we ? clr_addr : ad;
  assign wr_data = clr_we ? '0 : di;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[ad];

  generate
    if (OREG != 0) begin : g_oreg
      logic [DW-1:0] dout_r;

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_r <= '0;
        end else if (busy) begin
          dout_r <= '0;
        end else if ((WMODE == WMODE_WF) && user_we) begin
          dout_r <= di;
        end else begin
          // Read-first: the array read sees the word before this edge's write.
          dout_r <= rd_data;
        end
      end

      assign dout = dout_r;
    end else begin : g_comb
      // Zero latency; during a clear this shows the array as it is zeroed.
      assign dout = rd_data;
    end
  endgenerate

endmodule : dram_sp_gen
`default_nettype wire
